// File: rtl/bf_out_sched.sv
// Stage/word sequencer for the 4-BFU radix-2 NTT core.
// Issues one coefficient-word read per cycle with matching output-network
// lane selects, delays the write-back strobe/address by the butterfly
// latency, inserts a drain gap between stages and pulses done at the end.
module bf_out_sched #(
    parameter int unsigned LOG_N   = 8,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned BFU_LAT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inv,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic [2:0]        sel_a_0,
    output logic [2:0]        sel_a_1,
    output logic [2:0]        sel_a_2,
    output logic [2:0]        sel_a_3,
    output logic [2:0]        sel_a_4,
    output logic [2:0]        sel_a_5,
    output logic [2:0]        sel_a_6,
    output logic [2:0]        sel_a_7,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_bank,
    output logic [2:0]        stage,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LastWord  = ADDR_W'((1 << (LOG_N - 3)) - 1);
    localparam logic [2:0]        LastStage = 3'(LOG_N - 1);
    localparam int unsigned       WaitW     = $clog2(BFU_LAT + 1);
    localparam logic [WaitW-1:0]  WaitLoad  = WaitW'(BFU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StWait, StDone} state_t;

    state_t            state;
    logic [ADDR_W-1:0] word;
    logic [WaitW-1:0]  wait_cnt;
    logic              inv_run;
    logic [2:0]        sel [8];

    logic [BFU_LAT-1:0] en_dly;
    logic [BFU_LAT-1:0] bank_dly;
    logic [ADDR_W-1:0]  addr_dly [BFU_LAT];

    // Forward transforms shuffle on the last three stages, inverse on the first three.
    function automatic logic use_shuffle(input logic iv, input logic [2:0] stg);
        if (iv) return stg < 3'd3;
        return stg >= 3'(LOG_N - 3);
    endfunction

    // Lane code {bfu_index, is_upper}; shuffle interleaves lanes across BFUs.
    function automatic logic [2:0] lane_code(input logic shuf, input logic [2:0] j);
        return shuf ? {j[1:0], ~j[2]} : {j[2:1], ~j[0]};
    endfunction

    assign rd_bank = stage[0];
    assign sel_a_0 = sel[0];
    assign sel_a_1 = sel[1];
    assign sel_a_2 = sel[2];
    assign sel_a_3 = sel[3];
    assign sel_a_4 = sel[4];
    assign sel_a_5 = sel[5];
    assign sel_a_6 = sel[6];
    assign sel_a_7 = sel[7];
    assign wr_en   = en_dly[BFU_LAT-1];
    assign wr_bank = bank_dly[BFU_LAT-1];
    assign wr_addr = addr_dly[BFU_LAT-1];

    // Sequencer FSM with registered read strobe, address, selects and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            word     <= '0;
            wait_cnt <= '0;
            inv_run  <= 1'b0;
            stage    <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int j = 0; j < 8; j++) sel[j] <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        inv_run <= inv;
                        stage   <= '0;
                        word    <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        state   <= StRun;
                        for (int j = 0; j < 8; j++) begin
                            sel[j] <= lane_code(use_shuffle(inv, 3'd0), 3'(j));
                        end
                    end
                end
                StRun: begin
                    if (word == LastWord) begin
                        rd_en    <= 1'b0;
                        rd_addr  <= '0;
                        wait_cnt <= WaitLoad;
                        state    <= StWait;
                        for (int j = 0; j < 8; j++) sel[j] <= '0;
                    end else begin
                        word    <= word + ADDR_W'(1);
                        rd_addr <= word + ADDR_W'(1);
                    end
                end
                StWait: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WaitW'(1);
                    end else if (stage == LastStage) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        stage   <= stage + 3'd1;
                        word    <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        state   <= StRun;
                        for (int j = 0; j < 8; j++) begin
                            sel[j] <= lane_code(use_shuffle(inv_run, stage + 3'd1), 3'(j));
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    stage <= '0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Write-back delay lines matching the butterfly pipeline latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_dly   <= '0;
            bank_dly <= '0;
            for (int i = 0; i < int'(BFU_LAT); i++) addr_dly[i] <= '0;
        end else begin
            en_dly   <= {en_dly[BFU_LAT-2:0], rd_en};
            bank_dly <= {bank_dly[BFU_LAT-2:0], ~rd_bank};
            addr_dly[0] <= rd_addr;
            for (int i = 1; i < int'(BFU_LAT); i++) addr_dly[i] <= addr_dly[i-1];
        end
    end

endmodule

// File: tb/tb_bf_out_sched.sv
// Self-checking bench for bf_out_sched: cycle-position model plus directed runs.
module tb_bf_out_sched;

    localparam int Words = 32;
    localparam int Lat   = 7;
    localparam int Slen  = Words + Lat;   // 39 cycles per stage
    localparam int Total = 8 * Slen + 1;  // done cycle, 313

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       inv = 1'b0;
    logic       rd_en, wr_en, rd_bank, wr_bank, busy, done;
    logic [4:0] rd_addr, wr_addr;
    logic [2:0] stage;
    logic [2:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3, sel_a_4, sel_a_5, sel_a_6, sel_a_7;
    logic [2:0] sel_v [8];

    int checks = 0;
    int failures = 0;

    int straight_tab [8] = '{1, 0, 3, 2, 5, 4, 7, 6};
    int shuffle_tab  [8] = '{1, 3, 5, 7, 0, 2, 4, 6};

    // Model: position inside the current run (0 = idle), and the run direction.
    int   run_t = 0;
    logic run_inv = 1'b0;

    // Per-cycle captures made by the stimulus task, indexed by run cycle.
    logic       r_rd_en [0:520];
    logic [4:0] r_rd_addr [0:520];
    logic [2:0] r_sel0 [0:520];
    logic [2:0] r_sel1 [0:520];
    logic [2:0] r_sel4 [0:520];
    logic [2:0] r_sel7 [0:520];
    logic       r_bank [0:520];
    logic       r_wr_en [0:520];
    logic [4:0] r_wr_addr [0:520];
    logic       r_busy [0:520];

    int cmp_t, cmp_s, cmp_p;
    bit cmp_rd, cmp_wr;

    bf_out_sched dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .inv     (inv),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_bank (rd_bank),
        .sel_a_0 (sel_a_0),
        .sel_a_1 (sel_a_1),
        .sel_a_2 (sel_a_2),
        .sel_a_3 (sel_a_3),
        .sel_a_4 (sel_a_4),
        .sel_a_5 (sel_a_5),
        .sel_a_6 (sel_a_6),
        .sel_a_7 (sel_a_7),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_bank (wr_bank),
        .stage   (stage),
        .busy    (busy),
        .done    (done)
    );

    assign sel_v[0] = sel_a_0;
    assign sel_v[1] = sel_a_1;
    assign sel_v[2] = sel_a_2;
    assign sel_v[3] = sel_a_3;
    assign sel_v[4] = sel_a_4;
    assign sel_v[5] = sel_a_5;
    assign sel_v[6] = sel_a_6;
    assign sel_v[7] = sel_a_7;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // A read happens in the first Words cycles of each of the 8 stage slots.
    function automatic bit exp_rd(input int t);
        if (t < 1 || t > 8 * Slen) return 1'b0;
        return ((t - 1) % Slen) < Words;
    endfunction

    // Track run position; start is only honoured while idle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_t <= 0;
        end else if (run_t == 0) begin
            if (start) begin
                run_t   <= 1;
                run_inv <= inv;
            end
        end else if (run_t == Total) begin
            run_t <= 0;
        end else begin
            run_t <= run_t + 1;
        end
    end

    // Compare every output against the model each cycle, away from the active edge.
    always @(negedge clk) begin
        cmp_t  = run_t;
        cmp_rd = exp_rd(cmp_t);
        cmp_s  = (cmp_t - 1) / Slen;
        cmp_p  = (cmp_t - 1) % Slen;
        chk("rd_en", int'(rd_en), int'(cmp_rd));
        chk("busy", int'(busy), int'(cmp_t >= 1));
        chk("done", int'(done), int'(cmp_t == Total));
        if (cmp_rd) begin
            chk("rd_addr", int'(rd_addr), cmp_p);
            for (int j = 0; j < 8; j++) begin
                if (run_inv ? (cmp_s < 3) : (cmp_s >= 5))
                    chk($sformatf("sel_a_%0d", j), int'(sel_v[j]), shuffle_tab[j]);
                else
                    chk($sformatf("sel_a_%0d", j), int'(sel_v[j]), straight_tab[j]);
            end
        end else begin
            for (int j = 0; j < 8; j++) chk($sformatf("sel_a_%0d_idle", j), int'(sel_v[j]), 0);
        end
        if (cmp_t >= 1 && cmp_t <= 8 * Slen) begin
            chk("stage", int'(stage), cmp_s);
            chk("rd_bank", int'(rd_bank), cmp_s % 2);
        end
        cmp_wr = exp_rd(cmp_t - Lat);
        chk("wr_en", int'(wr_en), int'(cmp_wr));
        if (cmp_wr) begin
            chk("wr_addr", int'(wr_addr), (cmp_t - Lat - 1) % Slen);
            chk("wr_bank", int'(wr_bank), 1 - (((cmp_t - Lat - 1) / Slen) % 2));
        end
    end

    // Start a run and capture outputs per cycle; optionally hold start or reset mid-run.
    task automatic run_one(input logic iv, input int hold_from, input int hold_to,
                           input int rst_at, input int max_cyc,
                           output int done_cyc, output int done_cnt, output int rd_cnt);
        done_cyc = 0;
        done_cnt = 0;
        rd_cnt   = 0;
        @(posedge clk); #1;
        start = 1'b1;
        inv   = iv;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            r_rd_en[cyc]   = rd_en;
            r_rd_addr[cyc] = rd_addr;
            r_sel0[cyc]    = sel_a_0;
            r_sel1[cyc]    = sel_a_1;
            r_sel4[cyc]    = sel_a_4;
            r_sel7[cyc]    = sel_a_7;
            r_bank[cyc]    = rd_bank;
            r_wr_en[cyc]   = wr_en;
            r_wr_addr[cyc] = wr_addr;
            r_busy[cyc]    = busy;
            if (cyc <= Total) begin
                if (rd_en) rd_cnt++;
                if (done) done_cnt++;
            end
            if (done && done_cyc == 0) done_cyc = cyc;
            if (cyc == hold_from) start = 1'b1;
            if (cyc == hold_to) start = 1'b0;
            if (cyc == rst_at) begin
                #1 rst = 1'b0;
                #1;
                chk("rst_rd_en", int'(rd_en), 0);
                chk("rst_wr_en", int'(wr_en), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_stage", int'(stage), 0);
                chk("rst_sel_a_7", int'(sel_a_7), 0);
                break;
            end
            @(posedge clk); #2;
        end
    endtask

    int dc, dn, rc;

    initial begin
        // Reset values
        #3;
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_stage", int'(stage), 0);
        chk("reset_sel_a_0", int'(sel_a_0), 0);
        chk("reset_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // Forward run
        run_one(1'b0, -1, -1, -1, 320, dc, dn, rc);
        chk("fwd_done_cycle", dc, 313);
        chk("fwd_done_pulses", dn, 1);
        chk("fwd_read_count", rc, 256);
        chk("fwd_busy_at_done", int'(r_busy[313]), 1);
        chk("fwd_busy_after_done", int'(r_busy[314]), 0);
        chk("fwd_s0_lane7", int'(r_sel7[1]), 3'b110);
        chk("fwd_s0_lane1", int'(r_sel1[1]), 3'b000);
        chk("fwd_s5_lane1", int'(r_sel1[196]), 3'b011);
        chk("fwd_s5_lane4", int'(r_sel4[196]), 3'b000);
        chk("fwd_wait_sel0", int'(r_sel0[33]), 0);
        chk("fwd_wait_rd_en", int'(r_rd_en[33]), 0);
        chk("fwd_last_wr_en", int'(r_wr_en[39]), 1);
        chk("fwd_last_wr_addr", int'(r_wr_addr[39]), 31);
        chk("fwd_s1_rd_en", int'(r_rd_en[40]), 1);
        chk("fwd_s1_rd_addr", int'(r_rd_addr[40]), 0);
        chk("fwd_s1_wr_en", int'(r_wr_en[40]), 0);
        repeat (4) @(posedge clk);

        // Inverse run
        run_one(1'b1, -1, -1, -1, 320, dc, dn, rc);
        chk("inv_done_cycle", dc, 313);
        chk("inv_s0_lane1", int'(r_sel1[1]), 3'b011);
        chk("inv_s0_lane4", int'(r_sel4[1]), 3'b000);
        chk("inv_s3_lane1", int'(r_sel1[118]), 3'b000);
        chk("inv_s3_lane7", int'(r_sel7[118]), 3'b110);
        chk("inv_bank_s0", int'(r_bank[1]), 0);
        chk("inv_bank_s1", int'(r_bank[40]), 1);
        chk("inv_bank_s2", int'(r_bank[79]), 0);
        repeat (4) @(posedge clk);

        // Start held from cycle 50 across done; second run reset in stage 3 WAIT
        run_one(1'b0, 50, 316, 466, 500, dc, dn, rc);
        chk("hold_done_cycle", dc, 313);
        chk("hold_done_pulses", dn, 1);
        chk("hold_idle_gap", int'(r_rd_en[314]), 0);
        chk("hold_restart", int'(r_rd_en[315]), 1);
        chk("hold_restart_addr", int'(r_rd_addr[315]), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);

        // Full run after mid-run reset
        run_one(1'b0, -1, -1, -1, 320, dc, dn, rc);
        chk("post_rst_done_cycle", dc, 313);
        chk("post_rst_read_count", rc, 256);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
